// File: rtl/keypad_pkg.sv
// Shared FSM state type, key-code constants and one-hot decode helpers
// for the keypad decoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    function automatic logic is_onehot(input logic [11:0] vec);
        return (vec != 12'd0) && ((vec & (vec - 12'd1)) == 12'd0);
    endfunction

    // Scanner bit order: 0..8 = keys 1..9, 9 = *, 10 = 0, 11 = #.
    function automatic logic [3:0] onehot_to_code(input logic [11:0] vec);
        logic [3:0] code;
        case (vec)
            12'h001: code = KEY_1;
            12'h002: code = KEY_2;
            12'h004: code = KEY_3;
            12'h008: code = KEY_4;
            12'h010: code = KEY_5;
            12'h020: code = KEY_6;
            12'h040: code = KEY_7;
            12'h080: code = KEY_8;
            12'h100: code = KEY_9;
            12'h200: code = KEY_STAR;
            12'h400: code = KEY_0;
            12'h800: code = KEY_HASH;
            default: code = KEY_0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Key-event FIFO: binary pointers with a wrap bit, registered head data
// that holds its last value when empty, and a sticky drop flag.
module keypad_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             overflow
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic [AW:0]      wptr_nxt_s;
    logic [AW:0]      rptr_nxt_s;
    logic             empty_s;
    logic             full_s;
    logic             rd_ok_s;
    logic             wr_ok_s;
    logic             drop_s;
    logic [WIDTH-1:0] head_nxt_s;
    logic [WIDTH-1:0] rd_data_r;
    logic             rd_valid_r;
    logic             overflow_r;

    // Occupancy, accepted push/pop and the head value after this cycle.
    always_comb begin
        empty_s    = (wptr_r == rptr_r);
        full_s     = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
        rd_ok_s    = rd_en && !empty_s;
        wr_ok_s    = wr_en && (!full_s || rd_ok_s);
        drop_s     = wr_en && full_s && !rd_ok_s;
        wptr_nxt_s = wr_ok_s ? (wptr_r + PTR_ONE) : wptr_r;
        rptr_nxt_s = rd_ok_s ? (rptr_r + PTR_ONE) : rptr_r;
        // The new head is the incoming word when it lands in the slot being exposed.
        if (wr_ok_s && (wptr_r[AW-1:0] == rptr_nxt_s[AW-1:0])) begin
            head_nxt_s = wr_data;
        end else begin
            head_nxt_s = mem_r[rptr_nxt_s[AW-1:0]];
        end
    end

    // Storage array; contents are qualified by the pointers so it has no reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Pointers, registered head/valid and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r     <= {(AW+1){1'b0}};
            rptr_r     <= {(AW+1){1'b0}};
            rd_data_r  <= {WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            wptr_r     <= wptr_nxt_s;
            rptr_r     <= rptr_nxt_s;
            rd_valid_r <= (wptr_nxt_s != rptr_nxt_s);
            if (wptr_nxt_s != rptr_nxt_s) begin
                rd_data_r <= head_nxt_s;
            end
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/keypad_decoder.sv
// Debounced keypad decoder feeding a key-event FIFO.
// Optional auto-repeat while held is enabled by defining KEYPAD_DECODER_REPEAT_EN.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RELEASE_CYCLES  = 50000,
    parameter int FIFO_DEPTH      = 4
`ifdef KEYPAD_DECODER_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 150000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] key_data,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        key_held,
    output logic        overflow
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
    // Terms are compared against the pre-increment count, the latch cycle being the first.
    localparam logic [CW-1:0] DEB_TERM = CW'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0);
    localparam logic [CW-1:0] REL_TERM = CW'((RELEASE_CYCLES > 1) ? RELEASE_CYCLES - 2 : 0);

    kp_state_e     state_r;
    kp_state_e     state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [CW-1:0] cnt_inc_s;
    logic [11:0]   cand_r;
    logic [11:0]   cand_nxt_s;
    logic          held_r;
    logic          deb_push_s;
    logic          push_s;
    logic [3:0]    push_code_s;

    // Next state, counter and candidate; the debounce push fires on acceptance.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cand_nxt_s  = cand_r;
        deb_push_s  = 1'b0;
        cnt_inc_s   = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + CNT_ONE);
        case (state_r)
            ST_IDLE: begin
                if (is_onehot(key_data)) begin
                    cand_nxt_s  = key_data;
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = ST_DEBOUNCE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                if (key_data != cand_r) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r >= DEB_TERM) begin
                    deb_push_s  = 1'b1;
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = ST_HELD;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            ST_HELD: begin
                if (key_data == 12'h000) begin
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_HELD;
                end
            end
            ST_RELEASE: begin
                if (key_data != 12'h000) begin
                    state_nxt_s = ST_HELD;
                end else if (cnt_r >= REL_TERM) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // FSM, counter, candidate and held-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            cand_r  <= 12'h000;
            held_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            cand_r  <= cand_nxt_s;
            held_r  <= (state_nxt_s == ST_HELD) || (state_nxt_s == ST_RELEASE);
        end
    end

`ifdef KEYPAD_DECODER_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    localparam logic [RW-1:0] RPT_ONE     = RW'(1);
    localparam logic [RW-1:0] RPT_SAT     = {RW{1'b1}};
    localparam logic [RW-1:0] DELAY_TERM  = RW'((REPEAT_DELAY > 1) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] PERIOD_TERM = RW'((REPEAT_PERIOD > 1) ? REPEAT_PERIOD - 1 : 0);

    logic [RW-1:0] rpt_cnt_r;
    logic [RW-1:0] rpt_cnt_nxt_s;
    logic          rpt_armed_r;
    logic          rpt_armed_nxt_s;
    logic          rpt_push_s;

    // Repeat timer: counts held cycles only, frozen across a release attempt.
    always_comb begin
        rpt_cnt_nxt_s   = rpt_cnt_r;
        rpt_armed_nxt_s = rpt_armed_r;
        rpt_push_s      = 1'b0;
        if (deb_push_s) begin
            rpt_cnt_nxt_s   = {RW{1'b0}};
            rpt_armed_nxt_s = 1'b0;
        end else if ((state_r == ST_HELD) && (key_data != 12'h000)) begin
            if (rpt_cnt_r >= (rpt_armed_r ? PERIOD_TERM : DELAY_TERM)) begin
                rpt_push_s      = 1'b1;
                rpt_cnt_nxt_s   = {RW{1'b0}};
                rpt_armed_nxt_s = 1'b1;
            end else begin
                rpt_cnt_nxt_s = (rpt_cnt_r == RPT_SAT) ? rpt_cnt_r : (rpt_cnt_r + RPT_ONE);
            end
        end else begin
            rpt_cnt_nxt_s = rpt_cnt_r;
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_r   <= {RW{1'b0}};
            rpt_armed_r <= 1'b0;
        end else begin
            rpt_cnt_r   <= rpt_cnt_nxt_s;
            rpt_armed_r <= rpt_armed_nxt_s;
        end
    end

    assign push_s = deb_push_s | rpt_push_s;
`else
    assign push_s = deb_push_s;
`endif

    assign push_code_s = onehot_to_code(cand_r);
    assign key_held    = held_r;

    keypad_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push_s),
        .wr_data  (push_code_s),
        .rd_en    (key_ready),
        .rd_data  (key_code),
        .rd_valid (key_valid),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder: vector table, directed corner
// sequences and randomized stimulus against a run-length reference model.
module tb_keypad_decoder;

    localparam int DEB     = 8;
    localparam int REL     = 8;
    localparam int DEPTH   = 4;
    localparam int RDELAY  = 20;
    localparam int RPERIOD = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] key_data;
    logic        key_ready;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        overflow;

    always #5 clk = ~clk;

    keypad_decoder #(
        .DEBOUNCE_CYCLES (DEB),
        .RELEASE_CYCLES  (REL),
        .FIFO_DEPTH      (DEPTH)
`ifdef KEYPAD_DECODER_REPEAT_EN
        ,
        .REPEAT_DELAY    (RDELAY),
        .REPEAT_PERIOD   (RPERIOD)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_data  (key_data),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: run lengths rather than FSM states.
    int          m_stable;
    int          m_zero;
    int          m_hold_len;
    logic [11:0] m_cand;
    bit          m_pressed;
    int          m_code;
    bit          m_ovf;
    int          q[$];
    int          nvalid;

    function automatic int code_of(input logic [11:0] k);
        int tab[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
        for (int b = 0; b < 12; b++) begin
            if (k[b]) return tab[b];
        end
        return 0;
    endfunction

    task automatic model_step(input logic r, input logic [11:0] k, input logic rdy);
        bit do_push = 1'b0;
        bit had = (q.size() > 0);
        if (r) begin
            m_stable = 0; m_zero = 0; m_hold_len = 0; m_cand = 12'h000;
            m_pressed = 1'b0; m_code = 0; m_ovf = 1'b0; q.delete();
            return;
        end
        if (!m_pressed) begin
            if (m_stable > 0) begin
                if (k == m_cand) begin
                    m_stable++;
                    if (m_stable >= DEB) begin
                        do_push = 1'b1; m_pressed = 1'b1;
                        m_stable = 0; m_zero = 0; m_hold_len = 0;
                    end
                end else begin
                    m_stable = 0;
                end
            end else if ($countones(k) == 1) begin
                m_cand = k; m_stable = 1;
            end
        end else begin
            if (k == 12'h000) begin
                m_zero++;
                if (m_zero >= REL) begin m_pressed = 1'b0; m_zero = 0; end
            end else if (m_zero > 0) begin
                m_zero = 0;
            end else begin
                m_hold_len++;
`ifdef KEYPAD_DECODER_REPEAT_EN
                if (m_hold_len == RDELAY ||
                    (m_hold_len > RDELAY && ((m_hold_len - RDELAY) % RPERIOD) == 0))
                    do_push = 1'b1;
`endif
            end
        end
        if (had && rdy) void'(q.pop_front());
        if (do_push) begin
            if (q.size() < DEPTH) q.push_back(code_of(m_cand));
            else m_ovf = 1'b1;
        end
        if (q.size() > 0) m_code = q[0];
    endtask

    task automatic drive(input logic r, input logic [11:0] kd, input logic rdy);
        rst = r; key_data = kd; key_ready = rdy;
        @(posedge clk);
        #1;
        model_step(r, kd, rdy);
        if (key_valid === 1'b1) nvalid++;
    endtask

    task automatic check_model(input string name);
        vectors++;
        if (key_code !== 4'(m_code) || key_valid !== (q.size() > 0) ||
            key_held !== m_pressed || overflow !== m_ovf) begin
            miscompares++;
            $display("FAIL %s: got code=%0d valid=%0b held=%0b ovf=%0b, want code=%0d valid=%0b held=%0b ovf=%0b",
                     name, key_code, key_valid, key_held, overflow,
                     m_code, (q.size() > 0), m_pressed, m_ovf);
        end
    endtask

    task automatic run(input logic r, input logic [11:0] kd, input logic rdy, input string name);
        drive(r, kd, rdy);
        check_model(name);
    endtask

    task automatic expect_eq(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic [11:0] kd;
        logic        rdy;
        logic [3:0]  code;
        logic        valid;
        logic        held;
        logic        ovf;
    } vec_t;

    vec_t tbl[19];
    int   pop_exp[4] = '{10, 11, 0, 5};
    logic [11:0] seq_keys[5] = '{12'h200, 12'h800, 12'h400, 12'h010, 12'h040};
    int   obs[$];
    int   rep_exp[$];

    initial begin
        // Reset, single press of key 6 with ready high, then release timing.
        tbl[0] = '{1'b1, 12'h000, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 1; i <= 7; i++) tbl[i] = '{1'b0, 12'h020, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 12'h020, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 12'h020, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 12'h020, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0};
        for (int i = 11; i <= 17; i++) tbl[i] = '{1'b0, 12'h000, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 12'h000, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0};

        nvalid = 0;
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].r, tbl[i].kd, tbl[i].rdy);
            vectors++;
            if (key_code !== tbl[i].code || key_valid !== tbl[i].valid ||
                key_held !== tbl[i].held || overflow !== tbl[i].ovf) begin
                miscompares++;
                $display("FAIL table[%0d]: got code=%0d valid=%0b held=%0b ovf=%0b, want code=%0d valid=%0b held=%0b ovf=%0b",
                         i, key_code, key_valid, key_held, overflow,
                         tbl[i].code, tbl[i].valid, tbl[i].held, tbl[i].ovf);
            end
        end

        // Bounce: 5 + gap + 8 cycles gives one push; multi-hot gives none.
        nvalid = 0;
        for (int i = 0; i < 5; i++) run(1'b0, 12'h001, 1'b1, "bounce_a");
        run(1'b0, 12'h000, 1'b1, "bounce_gap");
        for (int i = 0; i < 8; i++) run(1'b0, 12'h001, 1'b1, "bounce_b");
        expect_eq("bounce_code", key_code, 1);
        for (int i = 0; i < 10; i++) run(1'b0, 12'h000, 1'b1, "bounce_rel");
        expect_eq("bounce_pushes", nvalid, 1);
        nvalid = 0;
        for (int i = 0; i < 20; i++) run(1'b0, 12'h003, 1'b1, "multihot");
        for (int i = 0; i < 2; i++) run(1'b0, 12'h000, 1'b1, "multihot_rel");
        expect_eq("multihot_pushes", nvalid, 0);

        // Five presses with no consumer: the fifth is dropped.
        foreach (seq_keys[k]) begin
            for (int i = 0; i < DEB; i++) run(1'b0, seq_keys[k], 1'b0, "fill_press");
            for (int i = 0; i < REL; i++) run(1'b0, 12'h000, 1'b0, "fill_rel");
        end
        expect_eq("fill_overflow", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            expect_eq("pop_valid", key_valid, 1);
            expect_eq("pop_code", key_code, pop_exp[i]);
            run(1'b0, 12'h000, 1'b1, "pop");
        end
        expect_eq("pop_empty", key_valid, 0);
        expect_eq("pop_ovf_sticky", overflow, 1);
        run(1'b1, 12'h000, 1'b1, "ovf_reset");

        // Release glitch on key 9.
        for (int i = 0; i < DEB; i++) run(1'b0, 12'h100, 1'b1, "k9_press");
        expect_eq("k9_code", key_code, 9);
        nvalid = 0;
        for (int i = 0; i < 4; i++) run(1'b0, 12'h000, 1'b1, "k9_gap");
        run(1'b0, 12'h100, 1'b1, "k9_glitch");
        expect_eq("k9_held_glitch", key_held, 1);
        for (int i = 0; i < 7; i++) run(1'b0, 12'h000, 1'b1, "k9_rel");
        expect_eq("k9_held_before_end", key_held, 1);
        run(1'b0, 12'h000, 1'b1, "k9_rel_last");
        expect_eq("k9_released", key_held, 0);
        expect_eq("k9_no_repush", nvalid, 0);

        // Reset in the middle of debouncing #.
        for (int i = 0; i < 4; i++) run(1'b0, 12'h800, 1'b1, "hash_deb");
        drive(1'b1, 12'h800, 1'b1);
        expect_eq("rst_code", key_code, 0);
        expect_eq("rst_valid", key_valid, 0);
        expect_eq("rst_held", key_held, 0);
        expect_eq("rst_ovf", overflow, 0);
        for (int i = 0; i < 7; i++) run(1'b0, 12'h800, 1'b1, "hash_redeb");
        expect_eq("hash_not_yet", key_valid, 0);
        run(1'b0, 12'h800, 1'b1, "hash_accept");
        expect_eq("hash_valid", key_valid, 1);
        expect_eq("hash_code", key_code, 11);
        for (int i = 0; i < REL + 1; i++) run(1'b0, 12'h000, 1'b1, "hash_rel");

        // Long hold of key 3: repeat schedule depends on the build option.
`ifdef KEYPAD_DECODER_REPEAT_EN
        rep_exp = '{8, 28, 38, 48};
`else
        rep_exp = '{8};
`endif
        for (int i = 1; i <= 50; i++) begin
            run(1'b0, 12'h004, 1'b1, "k3_hold");
            if (key_valid === 1'b1) begin
                obs.push_back(i);
                expect_eq("k3_code", key_code, 3);
            end
        end
        expect_eq("k3_push_count", obs.size(), rep_exp.size());
        foreach (rep_exp[i]) begin
            if (i < obs.size()) expect_eq("k3_push_cycle", obs[i], rep_exp[i]);
        end
        for (int i = 0; i < REL + 1; i++) run(1'b0, 12'h000, 1'b1, "k3_rel");

        // Randomized segments of keys, zeros, multi-hot and bursts of stalls.
        for (int seg = 0; seg < 80; seg++) begin
            logic [11:0] kd;
            int sel = $urandom_range(0, 9);
            int len = $urandom_range(1, 26);
            bit rdy_hi = ($urandom_range(0, 1) == 1);
            if (sel < 6) kd = 12'd1 << $urandom_range(0, 11);
            else if (sel < 8) kd = 12'h000;
            else kd = (12'd1 << $urandom_range(0, 11)) | (12'd1 << $urandom_range(0, 11));
            for (int i = 0; i < len; i++) begin
                logic [11:0] kc = ($urandom_range(0, 19) == 0) ? 12'h000 : kd;
                logic rd = rdy_hi ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                logic rr = ($urandom_range(0, 249) == 0);
                run(rr, kc, rd, "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_decoder.md
KEYPAD_DECODER -- requirements
Module: keypad_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: clk cycles a single key must be stable before acceptance.
REQ-002 SHALL have parameter RELEASE_CYCLES, default 50000: clk cycles of all-zero input before release is accepted.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: key-event buffer entries, power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port key_data, input, 12: one-hot key vector from the keypad scanner. Bits 0..8 are keys 1..9, bit 9 is *, bit 10 is 0, bit 11 is #.
REQ-007 SHALL have port key_code, output, 4: key code at the FIFO head.
REQ-008 SHALL have port key_valid, output, 1: FIFO not empty.
REQ-009 SHALL have port key_ready, input, 1: consumer pops the head when key_valid and key_ready are both high.
REQ-010 SHALL have port key_held, output, 1: high while the FSM is in HELD or RELEASE.
REQ-011 SHALL have port overflow, output, 1: sticky flag, set when an event is dropped.

Function
REQ-012 SHALL map key codes as: keys 1..9 to 1..9, key 0 to 0, * to 10 (4'hA), # to 11 (4'hB). Codes 12..15 are never produced.
REQ-013 SHALL treat key_data as valid only when exactly one bit is set. Zero and multi-hot values both count as "no key".
REQ-014 SHALL implement FSM IDLE, DEBOUNCE, HELD, RELEASE.
REQ-015 IDLE: on a valid key, latch it as the candidate, clear the counter, go to DEBOUNCE.
REQ-016 DEBOUNCE: each cycle key_data equals the candidate, increment the counter. Any other value returns to IDLE. When the counter reaches DEBOUNCE_CYCLES-1, push the candidate code and go to HELD.
REQ-017 HELD: when key_data is all-zero, clear the counter and go to RELEASE. Any other value, including a different key or multi-hot, stays in HELD with no push.
REQ-018 RELEASE: count consecutive all-zero cycles. Any non-zero value returns to HELD. Reaching RELEASE_CYCLES-1 goes to IDLE.
REQ-019 SHALL make the first pushed code visible on key_code/key_valid one cycle after the push cycle.
REQ-020 SHALL size the counter as $clog2 of the largest cycle parameter in use, and SHALL saturate it, never wrap.
REQ-021 SHALL implement the FIFO with FIFO_DEPTH entries, binary read/write pointers and an extra wrap bit.
REQ-022 Push while full with no pop in the same cycle: drop the new code and set overflow. Overflow stays set until reset.
REQ-023 Push and pop in the same cycle while full: both SHALL occur, with no overflow.
REQ-024 Pop while empty SHALL be ignored.
REQ-025 key_code SHALL hold its last value when the FIFO is empty.

Reset
REQ-026 On rst high at a clk edge, SHALL set: state IDLE, counters 0, FIFO empty, key_code 0, key_valid 0, key_held 0, overflow 0.
REQ-027 Reset mid-debounce or mid-hold SHALL discard the candidate. A key still pressed after reset SHALL be re-debounced from IDLE.

Configuration
REQ-028 Macro KEYPAD_DECODER_REPEAT_EN, when defined, SHALL add auto-repeat. In HELD, the same code is re-pushed after REPEAT_DELAY cycles (parameter, default 500000), then every REPEAT_PERIOD cycles (parameter, default 150000). The repeat counter is reset when entering HELD from DEBOUNCE and resumes on return from RELEASE.
REQ-029 Without the macro, exactly one push SHALL occur per press, and the repeat parameters and logic SHALL be absent.

Structure
REQ-030 Package keypad_pkg SHALL hold the FSM state enum, the key code constants (KEY_0..KEY_9, KEY_STAR=10, KEY_HASH=11) and the onehot-to-code function.
REQ-031 The FIFO SHALL be sub-module keypad_fifo (parameterised width and depth).

Verification (bench uses DEBOUNCE_CYCLES=RELEASE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=10)
REQ-032 Hold key_data=12'h020 for 8 cycles, key_ready=1 -> key_code=6 with key_valid high for exactly one cycle, key_held=1.
REQ-033 Bounce: 12'h001 for 5 cycles, 0 for 1 cycle, 12'h001 for 8 cycles -> exactly one push of code 1. Multi-hot 12'h003 held for 20 cycles -> no push.
REQ-034 With key_ready=0, press and release * , #, 0, 5, 7 in turn -> FIFO holds A, B, 0, 5 and overflow=1. Then raise key_ready -> pops in that order and key_valid falls after 4 pops.
REQ-035 Release glitch: in HELD with key 9, apply 0 for 4 cycles then 12'h100 -> stays HELD, no second push. Then 0 for 8 cycles -> IDLE.
REQ-036 Assert rst during DEBOUNCE with key 12'h800 held -> outputs return to reset values. After rst falls, code 11 is pushed 8 cycles later.
REQ-037 With KEYPAD_DECODER_REPEAT_EN defined, hold key 3 for 50 cycles -> pushes at the debounce point, +20 cycles, +30 cycles, +40 cycles. Without the macro -> a single push.
